// File: rtl/string_frame_generator_pkg.sv
// Shared types and defaults for the serial frame generator and its match counter.
package string_frame_generator_pkg;

   localparam int unsigned FRAME_LEN_DEF = 20;
   localparam int unsigned GUARD_LEN_DEF = 4;
   localparam int unsigned PAT_W_DEF     = 4;
   localparam int unsigned CNT_W_DEF     = 4;

   function automatic int unsigned bit_cnt_w(input int unsigned frame_len,
                                             input int unsigned guard_len);
      return $clog2(frame_len + guard_len);
   endfunction

   localparam int unsigned BIT_CNT_W = bit_cnt_w(FRAME_LEN_DEF, GUARD_LEN_DEF);

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StGuard
   } state_e;

endpackage

// File: rtl/string_frame_generator_pattern_match_counter.sv
// Non-overlapping left-to-right pattern counter over a serial bit stream.
// count includes the bit strobed this cycle, so the caller can register the final value.
module pattern_match_counter
   import string_frame_generator_pkg::*;
#(
   parameter int unsigned PAT_W = PAT_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din,
   input  logic             bit_strobe,
   input  logic             window_ok,
   input  logic             clear,
   input  logic [PAT_W-1:0] pattern,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned LockW = $clog2(PAT_W + 1);

   logic [PAT_W-1:0] hist_q, hist_d;
   logic [LockW-1:0] lock_q, lock_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      hist_d = hist_q;
      lock_d = lock_q;
      cnt_d  = cnt_q;
      if (clear) begin
         hist_d = '0;
         lock_d = '0;
         cnt_d  = '0;
      end else if (bit_strobe) begin
         hist_d = {hist_q[PAT_W-2:0], din};
         // A hit locks out the next PAT_W-1 windows, which gives non-overlapping matching.
         if (window_ok && (lock_q == '0) && (hist_d == pattern)) begin
            cnt_d  = cnt_q + 1'b1;
            lock_d = LockW'(PAT_W - 1);
         end else if (lock_q != '0) begin
            lock_d = lock_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= '0;
         lock_q <= '0;
         cnt_q  <= '0;
      end else begin
         hist_q <= hist_d;
         lock_q <= lock_d;
         cnt_q  <= cnt_d;
      end
   end

   assign count = cnt_d;

endmodule

// File: rtl/string_frame_generator.sv
// Serial frame transmitter: shifts a frame MSB-first, then a guard gap, and reports the
// golden non-overlapping match count of the pattern in the frame.
module string_frame_generator
   import string_frame_generator_pkg::*;
#(
   parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
   parameter int unsigned GUARD_LEN = GUARD_LEN_DEF,
   parameter int unsigned PAT_W     = PAT_W_DEF,
   parameter int unsigned CNT_W     = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_valid,
   output logic                 load_ready,
   input  logic [FRAME_LEN-1:0] frame_data,
   input  logic [PAT_W-1:0]     pattern,
   output logic                 serial_out,
   output logic                 bit_valid,
   output logic                 frame_start,
   output logic                 guard,
   output logic [CNT_W-1:0]     expected_n,
   output logic                 n_valid
);

   localparam int unsigned BitCntW = bit_cnt_w(FRAME_LEN, GUARD_LEN);

   state_e               state_q;
   logic [FRAME_LEN-1:0] shreg_q;
   logic [PAT_W-1:0]     pat_q;
   logic [BitCntW-1:0]   bit_cnt_q;
   logic                 serial_out_q;
   logic                 bit_valid_q;
   logic                 frame_start_q;
   logic                 guard_q;
   logic [CNT_W-1:0]     expected_n_q;
   logic                 n_valid_q;

   logic                 accept;
   logic [CNT_W-1:0]     match_count;

   assign load_ready = (state_q == StIdle);
   assign accept     = load_ready && load_valid;

   pattern_match_counter #(
      .PAT_W (PAT_W),
      .CNT_W (CNT_W)
   ) u_match (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (serial_out_q),
      .bit_strobe (state_q == StSend),
      .window_ok  (bit_cnt_q >= BitCntW'(PAT_W - 1)),
      .clear      (accept),
      .pattern    (pat_q),
      .count      (match_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         shreg_q       <= '0;
         pat_q         <= '0;
         bit_cnt_q     <= '0;
         serial_out_q  <= 1'b0;
         bit_valid_q   <= 1'b0;
         frame_start_q <= 1'b0;
         guard_q       <= 1'b0;
         expected_n_q  <= '0;
         n_valid_q     <= 1'b0;
      end else begin
         frame_start_q <= 1'b0;
         n_valid_q     <= 1'b0;
         unique case (state_q)
            StIdle: begin
               serial_out_q <= 1'b0;
               bit_valid_q  <= 1'b0;
               guard_q      <= 1'b0;
               if (load_valid) begin
                  // The MSB goes straight to serial_out; the rest waits in the shifter.
                  shreg_q       <= {frame_data[FRAME_LEN-2:0], 1'b0};
                  pat_q         <= pattern;
                  serial_out_q  <= frame_data[FRAME_LEN-1];
                  bit_valid_q   <= 1'b1;
                  frame_start_q <= 1'b1;
                  bit_cnt_q     <= '0;
                  state_q       <= StSend;
               end
            end
            StSend: begin
               if (bit_cnt_q == BitCntW'(FRAME_LEN - 1)) begin
                  state_q      <= StGuard;
                  serial_out_q <= 1'b0;
                  bit_valid_q  <= 1'b0;
                  guard_q      <= 1'b1;
                  bit_cnt_q    <= '0;
                  expected_n_q <= match_count;
                  n_valid_q    <= 1'b1;
               end else begin
                  serial_out_q <= shreg_q[FRAME_LEN-1];
                  shreg_q      <= {shreg_q[FRAME_LEN-2:0], 1'b0};
                  bit_cnt_q    <= bit_cnt_q + 1'b1;
               end
            end
            StGuard: begin
               if (bit_cnt_q == BitCntW'(GUARD_LEN - 1)) begin
                  state_q   <= StIdle;
                  guard_q   <= 1'b0;
                  bit_cnt_q <= '0;
               end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign serial_out  = serial_out_q;
   assign bit_valid   = bit_valid_q;
   assign frame_start = frame_start_q;
   assign guard       = guard_q;
   assign expected_n  = expected_n_q;
   assign n_valid     = n_valid_q;

endmodule
